// File: rtl/pixel_serializer.sv
// pixel_serializer
//   Accepts a packed vector of NUM_PIX pixels through a valid/ready handshake
//   and emits it one pixel per beat, pixel 0 first, with downstream backpressure.
//   A final beat that completes while a new vector is offered loads that vector,
//   so consecutive vectors stream without a bubble.
//
// Parameters
//   NUM_PIX       pixels per input vector (2..16)
//   PIX_W         bits per pixel
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      pooledPixels holds a vector
//   in_ready      vector accepted this cycle (combinational in the final beat)
//   pooledPixels  packed input vector, element 0 is sent first
//   convResult    current output pixel (registered)
//   En            convResult is valid (registered)
//   out_ready     downstream accepts convResult this cycle
//   last          current beat is the final beat of the vector (registered)
//
// Build option
//   PIXEL_SERIALIZER_DUP_EN  when defined, every pixel is sent on two consecutive
//                            beats (2x nearest-neighbour upsample).
module pixel_serializer #(
  parameter int unsigned NUM_PIX = 4,
  parameter int unsigned PIX_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_PIX-1:0][PIX_W-1:0]  pooledPixels,
  output logic [PIX_W-1:0]               convResult,
  output logic                           En,
  input  logic                           out_ready,
  output logic                           last
);

  localparam int unsigned IDX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);

  typedef enum logic {StIdle, StSend} state_t;

  state_t                        state;
  logic [NUM_PIX-1:0][PIX_W-1:0] holding;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              nextIdx;
  logic                          beatDone;
  logic                          inXfer;
`ifdef PIXEL_SERIALIZER_DUP_EN
  // Set while the second copy of holding[idx] is on the output.
  logic                          second;
`endif

  assign beatDone = En && out_ready;
  // In SEND a new vector can only be taken as the final beat leaves.
  assign in_ready = (state == StIdle) || (last && out_ready);
  assign inXfer   = in_valid && in_ready;
  assign nextIdx  = idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      holding    <= '0;
      idx        <= '0;
      convResult <= '0;
      En         <= 1'b0;
      last       <= 1'b0;
`ifdef PIXEL_SERIALIZER_DUP_EN
      second     <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (inXfer) begin
            state      <= StSend;
            holding    <= pooledPixels;
            idx        <= '0;
            convResult <= pooledPixels[0];
            En         <= 1'b1;
            last       <= 1'b0;
`ifdef PIXEL_SERIALIZER_DUP_EN
            second     <= 1'b0;
`endif
          end
        end
        StSend: begin
          if (beatDone) begin
            if (last) begin
              if (inXfer) begin
                // Back-to-back reload: stay in SEND, restart at pixel 0.
                holding    <= pooledPixels;
                idx        <= '0;
                convResult <= pooledPixels[0];
                last       <= 1'b0;
`ifdef PIXEL_SERIALIZER_DUP_EN
                second     <= 1'b0;
`endif
              end else begin
                state      <= StIdle;
                idx        <= '0;
                convResult <= '0;
                En         <= 1'b0;
                last       <= 1'b0;
`ifdef PIXEL_SERIALIZER_DUP_EN
                second     <= 1'b0;
`endif
              end
            end else begin
`ifdef PIXEL_SERIALIZER_DUP_EN
              if (!second) begin
                // Repeat the same pixel; only the copy of the final pixel is last.
                second <= 1'b1;
                last   <= (idx == LAST_IDX);
              end else begin
                second     <= 1'b0;
                idx        <= nextIdx;
                convResult <= holding[nextIdx];
                last       <= 1'b0;
              end
`else
              idx        <= nextIdx;
              convResult <= holding[nextIdx];
              last       <= (nextIdx == LAST_IDX);
`endif
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// Directed bench for pixel_serializer. Every accepted vector pushes its expected
// beats into a queue; each cycle the head of the queue is compared with the
// output, and popped when the beat completes.
module tb_pixel_serializer;

  localparam int NUM_PIX = 4;
  localparam int PIX_W   = 8;
`ifdef PIXEL_SERIALIZER_DUP_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             lst;
  } beat_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [NUM_PIX-1:0][PIX_W-1:0] pooledPixels = '0;
  logic [PIX_W-1:0]              convResult;
  logic                          En;
  logic                          out_ready = 1'b0;
  logic                          last;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;
  bit    xfer;

  pixel_serializer #(
    .NUM_PIX(NUM_PIX),
    .PIX_W  (PIX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pooledPixels(pooledPixels),
    .convResult  (convResult),
    .En          (En),
    .out_ready   (out_ready),
    .last        (last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_vec(input logic [NUM_PIX-1:0][PIX_W-1:0] v);
    for (int i = 0; i < NUM_PIX; i++) begin
      for (int r = 0; r < REP; r++) begin
        q.push_back('{pix: v[i], lst: (i == NUM_PIX - 1) && (r == REP - 1)});
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the
  // next falling edge.
  task automatic cycle();
    logic expRdy;
    #1;
    xfer   = in_valid && in_ready;
    expRdy = (q.size() == 0) ? 1'b1 : (q[0].lst && out_ready);
    check("en", 32'(En), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(expRdy));
    if (q.size() != 0) begin
      check("pix", 32'(convResult), 32'(q[0].pix));
      check("last", 32'(last), 32'(q[0].lst));
      if (out_ready) begin
        void'(q.pop_front());
        beats++;
      end
    end else begin
      check("last_idle", 32'(last), 32'd0);
    end
    if (xfer) push_vec(pooledPixels);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
    check(tag, 32'(q.size()), 32'd0);
    cycle();
  endtask

  localparam logic [31:0] V1 = {8'h44, 8'h33, 8'h84, 8'h31};
  localparam logic [31:0] V2 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

  initial begin
    // Reset state
    #2;
    check("rst_conv", 32'(convResult), 32'd0);
    check("rst_en", 32'(En), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();

    // Single vector
    beats = 0;
    in_valid = 1'b1;
    pooledPixels = V1;
    cycle();
    in_valid = 1'b0;
    drain("single_drain");
    check("single_beats", 32'(beats), 32'(NUM_PIX * REP));

    // Back-to-back vectors
    beats = 0;
    in_valid = 1'b1;
    pooledPixels = V1;
    cycle();
    pooledPixels = V2;
    xfer = 1'b0;
    for (int i = 0; i < 20 && !xfer; i++) cycle();
    check("b2b_accept", 32'(xfer), 32'd1);
    in_valid = 1'b0;
    drain("b2b_drain");
    check("b2b_beats", 32'(beats), 32'(2 * NUM_PIX * REP));

    // Backpressure on the second beat
    beats = 0;
    in_valid = 1'b1;
    pooledPixels = V1;
    cycle();
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b0;
`ifndef PIXEL_SERIALIZER_DUP_EN
    #1;
    check("bp_pix84", 32'(convResult), 32'h84);
    @(negedge clk);
    cycle();
    cycle();
`else
    repeat (3) cycle();
`endif
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_beats", 32'(beats), 32'(NUM_PIX * REP));

    // Input changes while busy are ignored
    beats = 0;
    in_valid = 1'b1;
    pooledPixels = V2;
    cycle();
    in_valid = 1'b0;
    repeat (3) begin
      pooledPixels = $urandom;
      cycle();
    end
    drain("ign_drain");
    check("ign_beats", 32'(beats), 32'(NUM_PIX * REP));

    // Reset during the third beat
    in_valid = 1'b1;
    pooledPixels = V1;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_conv", 32'(convResult), 32'd0);
    check("mid_rst_en", 32'(En), 32'd0);
    check("mid_rst_last", 32'(last), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    beats = 0;
    in_valid = 1'b1;
    pooledPixels = {4{8'h5A}};
    cycle();
    in_valid = 1'b0;
    drain("post_rst_drain");
    check("post_rst_beats", 32'(beats), 32'(NUM_PIX * REP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_serializer.md
PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

Interface
REQ-001 SHALL have parameter NUM_PIX, default 4, number of pixels per input vector (range 2..16).
REQ-002 SHALL have parameter PIX_W, default 8, width of one pixel in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  pooledPixels holds a valid vector.
REQ-006 SHALL have port in_ready  output  1  the block accepts a vector this cycle.
REQ-007 SHALL have port pooledPixels  input  [NUM_PIX-1:0][PIX_W-1:0]  packed pixel vector to serialize.
REQ-008 SHALL have port convResult  output  PIX_W  current output pixel.
REQ-009 SHALL have port En  output  1  convResult is valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumer accepts convResult this cycle.
REQ-011 SHALL have port last  output  1  the current beat is the final beat of a vector.

Function
REQ-012 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output beat SHALL complete on a rising edge where En && out_ready.
REQ-013 The FSM SHALL have two states: IDLE and SEND.
REQ-014 In IDLE, in_ready SHALL be 1 and En SHALL be 0; an input transfer SHALL capture pooledPixels into a holding register, clear the index to 0, and move to SEND.
REQ-015 In SEND, En SHALL be 1 and convResult SHALL equal holding[idx]; pixel 0 SHALL be sent first, pixel NUM_PIX-1 last.
REQ-016 idx SHALL advance by 1 only on a completed output beat; while out_ready=0, convResult, idx and last SHALL be held stable.
REQ-017 last SHALL be 1 exactly when En=1 and the current beat is the final beat of the vector.
REQ-018 In SEND, in_ready SHALL be 1 only when last && out_ready (combinational); any other SEND cycle SHALL have in_ready=0.
REQ-019 A beat completing with last=1 while an input transfer occurs SHALL load the new vector, clear idx and stay in SEND, giving back-to-back beats with no bubble.
REQ-020 A beat completing with last=1 without an input transfer SHALL return the FSM to IDLE.
REQ-021 Latency SHALL be one cycle: a vector accepted at edge N drives pixel 0 with En=1 from edge N to edge N+1.
REQ-022 pooledPixels SHALL be sampled only on an input transfer; changes at other times SHALL have no effect.
REQ-023 idx SHALL be $clog2(NUM_PIX) bits wide, widened to 1 bit minimum; idx SHALL never exceed the final beat index.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, idx=0, holding register=0, convResult=0, En=0, last=0.
REQ-025 Reset asserted mid-vector SHALL discard remaining beats; after release the first output SHALL come from a newly accepted vector.
REQ-026 in_ready SHALL be 1 on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro PIXEL_SERIALIZER_DUP_EN SHALL, when defined, emit each pixel on two consecutive beats (2x nearest-neighbour upsample).
REQ-028 With the macro defined, a vector SHALL take 2*NUM_PIX beats, and last SHALL assert only on the second copy of pixel NUM_PIX-1.
REQ-029 With the macro undefined, each pixel SHALL be emitted exactly once, in NUM_PIX beats, and no duplication logic SHALL exist.

Verification
REQ-030 Single vector: reset, hold out_ready=1, send {8'h44,8'h33,8'h84,8'h31} (pixel 0 = 8'h31) -> convResult 31,84,33,44 on 4 consecutive cycles, last on the 44 beat, then En=0.
REQ-031 Back-to-back: second vector {8'hDD,8'hCC,8'hBB,8'hAA} held valid during the first vector -> 8 contiguous En beats, in_ready pulses exactly on the 44 beat.
REQ-032 Backpressure: out_ready=0 for 3 cycles while convResult=8'h84 -> 8'h84, En=1 and last=0 held stable, and no beat is lost or repeated.
REQ-033 Reset mid-vector: assert rst_n=0 during beat 2 -> all outputs 0 within the same cycle; after release a new vector {4{8'h5A}} yields exactly 4 beats of 5A.
REQ-034 With PIXEL_SERIALIZER_DUP_EN: vector from REQ-030 -> 31,31,84,84,33,33,44,44, with last only on the final 44.
REQ-035 Input ignored: change pooledPixels while in SEND with in_ready=0 -> output sequence unchanged.
